// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants and types for the five-stage pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Control field widths carried into ID/EX
  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  // Bit positions inside the M control field
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // Instruction placed in a killed or empty slot
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_EMPTY = '{valid: 1'b0, pc4: 32'h0, instr: NOP_INSTR};

endpackage
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : 32x32 register file, two combinational read ports, one write
//                port, with write-through bypass from the write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_addr,
  input  logic [4:0]  rb_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0][31:0] regs_q;
  logic [31:0][31:0] regs_d;
  logic              w_wr_en;

  // r0 is hardwired to zero, so writes to it are dropped
  assign w_wr_en = we && (waddr != 5'd0);

  // Next-state of the array: one entry updated on a qualified write
  always_comb begin
    regs_d = regs_q;
    if (w_wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage update; reset clears every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: same-cycle writeback wins over stored value, r0 reads zero
  always_comb begin
    ra_data = (ra_addr == 5'd0) ? 32'h0 : regs_q[ra_addr];
    rb_data = (rb_addr == 5'd0) ? 32'h0 : regs_q[rb_addr];
    if (w_wr_en && (waddr == ra_addr)) begin
      ra_data = wdata;
    end
    if (w_wr_en && (waddr == rb_addr)) begin
      rb_data = wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Instruction decode stage: IF/ID register, register file with
//                writeback bypass, load-use hazard detection and bubbling of
//                the control fields handed to ID/EX.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_pc4,
  input  logic [31:0]       if_instr,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rt,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  input  logic [WB_W-1:0]   dec_wb,
  input  logic [M_W-1:0]    dec_m,
  input  logic [EX_W-1:0]   dec_ex,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc4,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [31:0]       busA,
  output logic [31:0]       busB,
  output logic [WB_W-1:0]   wb_out,
  output logic [M_W-1:0]    m_out,
  output logic [EX_W-1:0]   ex_out,
  output logic              pc_write,
  output logic              stall
);

  if_id_t if_id_q;
  if_id_t if_id_d;
  logic   w_bubble;

  // IF/ID next value: flush kills the slot, stall holds it, else load from IF
  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d = IF_ID_EMPTY;
    end else if (!stall) begin
      if_id_d = '{valid: if_valid, pc4: if_pc4, instr: if_instr};
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q <= IF_ID_EMPTY;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign id_instr = if_id_q.instr;
  assign id_pc4   = if_id_q.pc4;
  assign rs       = if_id_q.instr[25:21];
  assign rt       = if_id_q.instr[20:16];
  assign rd       = if_id_q.instr[15:11];

  // Load-use hazard: the load in EX targets a source of the instruction in ID
  always_comb begin
    stall    = if_id_q.valid && ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == rs) || (ex_rt == rt));
    pc_write = !stall;
    w_bubble = stall || !if_id_q.valid;
  end

  // Control fields to ID/EX, zeroed when this slot must not execute
  always_comb begin
    wb_out = '0;
    m_out  = '0;
    ex_out = '0;
    if (!w_bubble) begin
      wb_out = dec_wb;
      m_out  = dec_m;
      ex_out = dec_ex;
    end
  end

  regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rs),
    .rb_addr (rt),
    .ra_data (busA),
    .rb_data (busB),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Directed-vector self-checking bench for id_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

  localparam logic [1:0] DWB  = 2'b10;
  localparam logic [2:0] DM   = 3'b010;
  localparam logic [3:0] DEX  = 4'b1011;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        ifv;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        exmr;
    logic [4:0]  exrt;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_ctl;
    logic        e_stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc4, if_instr;
  logic        if_valid, flush, ex_memread, wb_we;
  logic [4:0]  ex_rt, wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  dec_wb;
  logic [2:0]  dec_m;
  logic [3:0]  dec_ex;
  logic [31:0] id_instr, id_pc4, busA, busB;
  logic [4:0]  rs, rt, rd;
  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [3:0]  ex_out;
  logic        pc_write, stall;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .if_pc4(if_pc4), .if_instr(if_instr),
    .if_valid(if_valid), .flush(flush), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .dec_wb(dec_wb), .dec_m(dec_m), .dec_ex(dec_ex),
    .id_instr(id_instr), .id_pc4(id_pc4), .rs(rs), .rt(rt), .rd(rd),
    .busA(busA), .busB(busB), .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out),
    .pc_write(pc_write), .stall(stall)
  );

  function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t,
                                     input logic [4:0] d);
    return {6'h00, s, t, d, 11'h000};
  endfunction

  task automatic add(input logic r, input logic fl, input logic iv,
                     input logic [31:0] pc, input logic [31:0] ins,
                     input logic mr, input logic [4:0] er,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [31:0] ei, input logic [31:0] ep,
                     input logic [31:0] ea, input logic [31:0] eb,
                     input logic ec, input logic es);
    vec_t v;
    v.rst = r; v.flush = fl; v.ifv = iv; v.pc4 = pc; v.instr = ins;
    v.exmr = mr; v.exrt = er; v.we = we; v.wa = wa; v.wd = wd;
    v.e_instr = ei; v.e_pc4 = ep; v.e_a = ea; v.e_b = eb;
    v.e_ctl = ec; v.e_stall = es;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  // Drive one vector just after a posedge, check at negedge, advance a cycle
  task automatic apply(input vec_t v, input int idx);
    logic [31:0] ei;
    rst = v.rst; flush = v.flush; if_valid = v.ifv; if_pc4 = v.pc4;
    if_instr = v.instr; ex_memread = v.exmr; ex_rt = v.exrt;
    wb_we = v.we; wb_addr = v.wa; wb_data = v.wd;
    @(negedge clk);
    n_vec++;
    ei = v.e_instr;
    chk("id_instr", idx, id_instr, ei);
    chk("id_pc4",   idx, id_pc4,   v.e_pc4);
    chk("rs",       idx, {27'h0, rs}, {27'h0, ei[25:21]});
    chk("rt",       idx, {27'h0, rt}, {27'h0, ei[20:16]});
    chk("rd",       idx, {27'h0, rd}, {27'h0, ei[15:11]});
    chk("busA",     idx, busA, v.e_a);
    chk("busB",     idx, busB, v.e_b);
    chk("wb_out",   idx, {30'h0, wb_out}, v.e_ctl ? {30'h0, DWB} : 32'h0);
    chk("m_out",    idx, {29'h0, m_out},  v.e_ctl ? {29'h0, DM}  : 32'h0);
    chk("ex_out",   idx, {28'h0, ex_out}, v.e_ctl ? {28'h0, DEX} : 32'h0);
    chk("stall",    idx, {31'h0, stall},    {31'h0, v.e_stall});
    chk("pc_write", idx, {31'h0, pc_write}, {31'h0, !v.e_stall});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] i1, i2, i3, i4, i5;
    vec_t h;
    i1 = mk(5'd5, 5'd6, 5'd7);
    i2 = mk(5'd5, 5'd8, 5'd9);
    i3 = mk(5'd0, 5'd0, 5'd1);
    i4 = mk(5'd5, 5'd8, 5'd3);
    i5 = mk(5'd8, 5'd5, 5'd4);

    //   rst fl iv pc4         instr  mr ert  we wa    wdata          | e_instr e_pc4 e_a  e_b  ctl stall
    add(0, 0, 0, 32'h0,   32'h0, 0, 5'd0, 0, 5'd0, 32'h0,        32'h0, 32'h0,   32'h0,        32'h0,        0, 0); // idle after reset
    add(0, 0, 1, 32'h104, i1,    0, 5'd0, 1, 5'd6, 32'h12345678, 32'h0, 32'h0,   32'h0,        32'h0,        0, 0); // load i1, write r6
    add(0, 0, 1, 32'h108, i2,    0, 5'd0, 1, 5'd5, 32'hDEADBEEF, i1,    32'h104, 32'hDEADBEEF, 32'h12345678, 1, 0); // bypass r5
    add(0, 0, 1, 32'h10C, i3,    1, 5'd8, 1, 5'd0, 32'hFFFFFFFF, i2,    32'h108, 32'hDEADBEEF, 32'h0,        0, 1); // load-use on rt
    add(0, 0, 1, 32'h10C, i3,    1, 5'd9, 0, 5'd0, 32'h0,        i2,    32'h108, 32'hDEADBEEF, 32'h0,        1, 0); // held, unrelated ex_rt
    add(0, 1, 1, 32'h110, i4,    1, 5'd0, 1, 5'd0, 32'hFFFFFFFF, i3,    32'h10C, 32'h0,        32'h0,        1, 0); // ex_rt=0, r0 write, flush
    add(0, 0, 1, 32'h114, i5,    0, 5'd0, 0, 5'd0, 32'h0,        32'h0, 32'h0,   32'h0,        32'h0,        0, 0); // flushed slot
    add(0, 1, 1, 32'h118, i2,    1, 5'd8, 0, 5'd0, 32'h0,        i5,    32'h114, 32'h0,        32'hDEADBEEF, 0, 1); // stall on rs + flush
    add(0, 0, 0, 32'h0,   32'h0, 1, 5'd8, 0, 5'd0, 32'h0,        32'h0, 32'h0,   32'h0,        32'h0,        0, 0); // cleared, no stall

    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc4 = '0; if_instr = '0;
    ex_memread = 1'b0; ex_rt = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    dec_wb = DWB; dec_m = DM; dec_ex = DEX;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Synchronous reset in the middle of a load-use stall
    h = vecs[0];
    h.ifv = 1'b1; h.pc4 = 32'h108; h.instr = i2;
    apply(h, 100);                       // empty slot, i2 loads
    h.rst = 1'b1; h.exmr = 1'b1; h.exrt = 5'd8;
    h.e_instr = i2; h.e_pc4 = 32'h108; h.e_a = 32'hDEADBEEF; h.e_stall = 1'b1;
    apply(h, 101);                       // stalled while rst asserted
    h.rst = 1'b0;
    h.e_instr = 32'h0; h.e_pc4 = 32'h0; h.e_a = 32'h0; h.e_stall = 1'b0;
    apply(h, 102);                       // reset state, i2 loads again
    h.exmr = 1'b0; h.exrt = 5'd0; h.ifv = 1'b0; h.pc4 = 32'h0; h.instr = 32'h0;
    h.e_instr = i2; h.e_pc4 = 32'h108; h.e_a = 32'h0; h.e_b = 32'h0; h.e_ctl = 1'b1;
    apply(h, 103);                       // r5 was cleared by reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage pipeline. It holds the IF/ID pipeline register, the 32x32 register file with write-through bypass from MEM/WB, and load-use hazard detection. Its outputs feed the ID/EX register directly: Rs/Rt/Rd, busA/busB, and the WB/M/EX control fields, which are forced to a bubble on a stall or an invalid slot. It also returns pc_write to IF to freeze instruction fetch.

## Interface
Parameters:
- none. Widths are fixed by the ISA (32-bit data, 5-bit register indices).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- if_pc4  in  32  PC+4 from IF.
- if_instr  in  32  fetched instruction.
- if_valid  in  1  IF slot holds a real instruction.
- flush  in  1  taken branch/jump; kill the instruction in IF/ID.
- ex_memread  in  1  MemRead bit of ID/EX MReg (M[1]).
- ex_rt  in  5  RtReg of ID/EX.
- wb_we  in  1  MEM/WB RegWrite.
- wb_addr  in  5  MEM/WB destination register.
- wb_data  in  32  MEM/WB write data.
- dec_wb  in  2  WB control from the decoder (decoder reads id_instr).
- dec_m  in  3  M control {Branch, MemRead, MemWrite}.
- dec_ex  in  4  EX control.
- id_instr  out  32  IF/ID instruction, to the decoder.
- id_pc4  out  32  IF/ID PC+4.
- rs, rt, rd  out  5 each  id_instr[25:21], [20:16], [15:11].
- busA, busB  out  32  register file reads of rs/rt, after bypass.
- wb_out, m_out, ex_out  out  2/3/4  control to ID/EX. Zero when bubble.
- pc_write  out  1  0 freezes the IF PC.
- stall  out  1  load-use stall asserted this cycle.

## Operation
- IF/ID register: {valid, pc4, instr}.
  - rst: {0, 0, 0}.
  - flush: {0, 0, 0}. Flush wins over stall.
  - stall: hold.
  - otherwise: {if_valid, if_pc4, if_instr}.
- Hazard detection:
  - stall = valid && ex_memread && ex_rt != 0 && (ex_rt == rs || ex_rt == rt).
  - pc_write = !stall.
- Bubble = stall || !valid. On a bubble, wb_out, m_out and ex_out are 0. rs/rt/rd/busA/busB still reflect IF/ID.
- Register file:
  - Storage: 32 x 32.
  - Write: on posedge when wb_we && wb_addr != 0.
  - Register 0 always reads 0.
  - rst clears all entries.
- Read path:
  - Reads are combinational.
  - Bypass: if wb_we && wb_addr != 0 && wb_addr == rs, then busA = wb_data. busB uses the same rule against rt.
- No arithmetic is performed here.

## Timing
- IF to ID latency: 1 cycle (IF/ID register).
- All outputs are combinational from IF/ID state, the regfile and the current inputs. They are valid before the ID/EX posedge.
- Reset values:
  - IF/ID is cleared, so id_instr = 0, id_pc4 = 0, rs = rt = rd = 0, busA = busB = 0, and all control outputs are 0.
  - stall = 0, pc_write = 1.
- Load-use stall lasts exactly 1 cycle:
  - The ID/EX register captures a bubble, so next cycle ex_memread = 0 and the stall drops.
  - The held instruction then proceeds.
- Simultaneous events:
  - Same-cycle writeback and read of the same register: the new value is returned by bypass.
  - flush during stall: the slot is cleared, pc_write stays 0 for that cycle, and stall deasserts the next cycle.
  - rst mid-stall: the next cycle equals the reset state.

## Structure
- pipe_pkg holds the shared pipeline constants:
  - M bit indices: M_BRANCH = 2, M_MEMREAD = 1, M_MEMWRITE = 0.
  - NOP_INSTR = 32'h0.
  - Control widths: WB = 2, M = 3, EX = 4.
- One sub-module, regfile: two read ports, one write port, with the bypass logic inside.
- Hazard logic and the IF/ID register stay inline in id_stage.

## Test plan
- Reset then idle: hold rst for 2 cycles, then if_valid = 0.
  - Expect all outputs 0, pc_write = 1, stall = 0.
- Writeback bypass: write r5 = 32'hDEADBEEF via wb_* while the IF/ID instr has rs = 5 in the same cycle.
  - Expect busA = DEADBEEF that cycle and on later reads.
  - A write to r0 leaves busA = 0 for rs = 0.
- Load-use: ex_memread = 1, ex_rt = 8; IF/ID instr has rt = 8.
  - Expect stall = 1, pc_write = 0, controls 0, IF/ID held.
  - After ex_memread drops: stall = 0 and the real controls pass through.
- No false stall: ex_memread = 1 with ex_rt = 0, or with ex_rt unrelated to rs/rt.
  - Expect stall = 0.
- Flush: assert flush with a valid instruction arriving from IF.
  - Next cycle: valid = 0, id_instr = 0, controls 0.
  - flush together with stall: slot cleared.
- Sync reset mid-stream: rst = 1 for one cycle during a stall.
  - Next cycle matches the reset state, and regfile reads return 0.
